muldiv_unit: RTL and testbench

//  Iterative multiply/divide unit that owns the architectural HI/LO pair.
//  - Executes MULT/MULTU/DIV/DIVU over DATA_W+2 cycles; handles MTHI/MTLO.
//  - Drives oBusy back to the pipeline: stall MFHI/MFLO and new mul/div issue.
//  - Replaces the ALU's single-cycle HI/LO path; ALU reads oHI/oLO for MFHI/MFLO.

---
 rtl/muldiv_unit_pkg.sv | 43 ++++
 rtl/muldiv_div_step.sv | 31 +++
 rtl/muldiv_unit.sv | 169 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: ALU op codes,
// FSM state encoding and op-class helpers.
package muldiv_unit_pkg;

   localparam logic [4:0] OPMULT  = 5'h10;
   localparam logic [4:0] OPMULTU = 5'h11;
   localparam logic [4:0] OPDIV   = 5'h12;
   localparam logic [4:0] OPDIVU  = 5'h13;
   localparam logic [4:0] OPMTHI  = 5'h14;
   localparam logic [4:0] OPMTLO  = 5'h15;
   localparam logic [4:0] OPMADD  = 5'h16;
   localparam logic [4:0] OPMADDU = 5'h17;
   localparam logic [4:0] OPMSUB  = 5'h18;
   localparam logic [4:0] OPMSUBU = 5'h19;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_CALC = 2'd1,
      MD_FIX  = 2'd2
   } md_state_t;

   function automatic logic isBaseMulDiv(input logic [4:0] op);
      return (op == OPMULT) || (op == OPMULTU) || (op == OPDIV) || (op == OPDIVU);
   endfunction

   function automatic logic isMaddOp(input logic [4:0] op);
      return (op == OPMADD) || (op == OPMADDU) || (op == OPMSUB) || (op == OPMSUBU);
   endfunction

   function automatic logic isSubOp(input logic [4:0] op);
      return (op == OPMSUB) || (op == OPMSUBU);
   endfunction

   function automatic logic isDivOp(input logic [4:0] op);
      return (op == OPDIV) || (op == OPDIVU);
   endfunction

   // Signed ops take operand magnitudes and fix the sign up at the end.
   function automatic logic isSignedOp(input logic [4:0] op);
      return (op == OPMULT) || (op == OPDIV) || (op == OPMADD) || (op == OPMSUB);
   endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, and shift the quotient bit in.
module muldiv_div_step
   import muldiv_unit_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] iRem,
   input  logic [DATA_W-1:0] iQuo,
   input  logic [DATA_W-1:0] iDivisor,
   output logic [DATA_W-1:0] oRem,
   output logic [DATA_W-1:0] oQuo
);

   logic [DATA_W:0]   shifted;
   logic [DATA_W-1:0] diff;

   // The remainder stays below the divisor, so the difference fits in DATA_W bits.
   always_comb begin
      shifted = {iRem, iQuo[DATA_W-1]};
      diff    = shifted[DATA_W-1:0] - iDivisor;
      if (shifted >= {1'b0, iDivisor}) begin
         oRem = diff;
         oQuo = {iQuo[DATA_W-2:0], 1'b1};
      end else begin
         oRem = shifted[DATA_W-1:0];
         oQuo = {iQuo[DATA_W-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO pair.
// Define MULDIV_MADD_EN to enable MADD/MADDU/MSUB/MSUBU accumulation into HI/LO.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              iCLK,
   input  logic              iRST,
   input  logic              iStart,
   input  logic [4:0]        iOp,
   input  logic [DATA_W-1:0] iA,
   input  logic [DATA_W-1:0] iB,
   output logic [DATA_W-1:0] oHI,
   output logic [DATA_W-1:0] oLO,
   output logic              oBusy,
   output logic              oDone,
   output logic              oDivByZero
);

`ifdef MULDIV_MADD_EN
   localparam bit MADD_EN = 1'b1;
`else
   localparam bit MADD_EN = 1'b0;
`endif

   localparam int                CNT_W     = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

   md_state_t         stateQ, stateD;
   logic [CNT_W-1:0]  cntQ;
   logic [4:0]        opQ;
   logic              signAQ, signBQ;
   logic [DATA_W-1:0] aAbsQ, bAbsQ;
   logic [DATA_W-1:0] accHiQ, accLoQ;
   logic [DATA_W-1:0] hiQ, loQ;

   logic              opAccepted;
   logic              latchEn, stepEn, fixEn, mtHiEn, mtLoEn;

   assign opAccepted = isBaseMulDiv(iOp) || (MADD_EN && isMaddOp(iOp));

   // ---------------- FSM: state register ----------------
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) stateQ <= MD_IDLE;
      else      stateQ <= stateD;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      stateD = stateQ;
      case (stateQ)
         MD_IDLE: if (iStart && opAccepted) stateD = MD_CALC;
         MD_CALC: if (cntQ == LAST_STEP)    stateD = MD_FIX;
         MD_FIX:                            stateD = MD_IDLE;
         default:                           stateD = MD_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      oBusy   = (stateQ != MD_IDLE);
      latchEn = (stateQ == MD_IDLE) && iStart && opAccepted;
      mtHiEn  = (stateQ == MD_IDLE) && iStart && (iOp == OPMTHI);
      mtLoEn  = (stateQ == MD_IDLE) && iStart && (iOp == OPMTLO);
      stepEn  = (stateQ == MD_CALC);
      fixEn   = (stateQ == MD_FIX);
   end

   // ---------------- operand conditioning ----------------
   logic              aNeg, bNeg;
   logic [DATA_W-1:0] aAbs, bAbs;

   always_comb begin
      aNeg = isSignedOp(iOp) && iA[DATA_W-1];
      bNeg = isSignedOp(iOp) && iB[DATA_W-1];
      aAbs = aNeg ? -iA : iA;
      bAbs = bNeg ? -iB : iB;
   end

   // ---------------- iteration step ----------------
   logic [DATA_W:0]   mulSum;
   logic [DATA_W-1:0] divRem, divQuo;

   // Right-shifting shift-add: multiplier sits in accLo, product grows into accHi.
   assign mulSum = {1'b0, accHiQ} + (accLoQ[0] ? {1'b0, aAbsQ} : '0);

   muldiv_div_step #(.DATA_W(DATA_W)) uDivStep (
      .iRem     (accHiQ),
      .iQuo     (accLoQ),
      .iDivisor (bAbsQ),
      .oRem     (divRem),
      .oQuo     (divQuo)
   );

   // ---------------- sign fix-up / result selection ----------------
   logic                negRes, divZero;
   logic [2*DATA_W-1:0] prodS, hiLoNext;
   logic [DATA_W-1:0]   quoS, remS, aRaw;

   always_comb begin
      negRes  = signAQ ^ signBQ;
      divZero = (bAbsQ == '0);
      prodS   = negRes ? -{accHiQ, accLoQ} : {accHiQ, accLoQ};
      quoS    = negRes ? -accLoQ : accLoQ;
      remS    = signAQ ? -accHiQ : accHiQ;
      aRaw    = signAQ ? -aAbsQ : aAbsQ;
      if (isDivOp(opQ)) begin
         hiLoNext = divZero ? {aRaw, {DATA_W{1'b1}}} : {remS, quoS};
      end else if (MADD_EN && isMaddOp(opQ)) begin
         hiLoNext = isSubOp(opQ) ? ({hiQ, loQ} - prodS) : ({hiQ, loQ} + prodS);
      end else begin
         hiLoNext = prodS;
      end
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         cntQ       <= '0;
         opQ        <= '0;
         signAQ     <= 1'b0;
         signBQ     <= 1'b0;
         aAbsQ      <= '0;
         bAbsQ      <= '0;
         accHiQ     <= '0;
         accLoQ     <= '0;
         hiQ        <= '0;
         loQ        <= '0;
         oDone      <= 1'b0;
         oDivByZero <= 1'b0;
      end else begin
         oDone      <= 1'b0;
         oDivByZero <= 1'b0;
         if (mtHiEn) hiQ <= iA;
         if (mtLoEn) loQ <= iA;
         if (latchEn) begin
            opQ    <= iOp;
            signAQ <= aNeg;
            signBQ <= bNeg;
            aAbsQ  <= aAbs;
            bAbsQ  <= bAbs;
            accHiQ <= '0;
            accLoQ <= isDivOp(iOp) ? aAbs : bAbs;
            cntQ   <= '0;
         end
         if (stepEn) begin
            cntQ <= cntQ + 1'b1;
            if (isDivOp(opQ)) begin
               accHiQ <= divRem;
               accLoQ <= divQuo;
            end else begin
               accHiQ <= mulSum[DATA_W:1];
               accLoQ <= {mulSum[0], accLoQ[DATA_W-1:1]};
            end
         end
         if (fixEn) begin
            hiQ        <= hiLoNext[2*DATA_W-1:DATA_W];
            loQ        <= hiLoNext[DATA_W-1:0];
            oDone      <= 1'b1;
            oDivByZero <= isDivOp(opQ) && divZero;
         end
      end
   end

   assign oHI = hiQ;
   assign oLO = loQ;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (32-bit HI/LO mul/div unit).
module tb_muldiv_unit;
   import muldiv_unit_pkg::*;

   localparam int W = 32;

   logic         iCLK;
   logic         iRST;
   logic         iStart;
   logic [4:0]   iOp;
   logic [W-1:0] iA, iB;
   logic [W-1:0] oHI, oLO;
   logic         oBusy, oDone, oDivByZero;

   int nChecks = 0;
   int nFails  = 0;

   muldiv_unit #(.DATA_W(W)) dut (
      .iCLK       (iCLK),
      .iRST       (iRST),
      .iStart     (iStart),
      .iOp        (iOp),
      .iA         (iA),
      .iB         (iB),
      .oHI        (oHI),
      .oLO        (oLO),
      .oBusy      (oBusy),
      .oDone      (oDone),
      .oDivByZero (oDivByZero)
   );

   // ---------------- clock ----------------
   initial iCLK = 1'b0;
   always #5 iCLK = ~iCLK;

   // ---------------- checker ----------------
   task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nChecks++;
      if (obs !== exp) begin
         nFails++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- drivers ----------------
   // Issue a mul/div op, optionally poke iStart while busy, then check result and timing.
   task automatic runMd(input string tag, input logic [4:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] expHi,
                        input logic [W-1:0] expLo, input logic expDbz, input int pokeAt);
      int cyc;
      int idleCyc;
      @(negedge iCLK);
      iStart = 1'b1; iOp = op; iA = a; iB = b;
      @(negedge iCLK);
      iStart = 1'b0; iA = $urandom; iB = $urandom;
      checkVal({tag, "_busy"}, {63'd0, oBusy}, 64'd1);
      cyc = 0;
      idleCyc = 0;
      while (!oDone && cyc < 100) begin
         if (pokeAt != 0 && cyc == pokeAt) begin
            iStart = 1'b1; iOp = OPDIVU; iA = 32'd100; iB = 32'd7;
         end else begin
            iStart = 1'b0;
         end
         @(negedge iCLK);
         cyc++;
         if (!oBusy && !oDone) idleCyc++;
      end
      iStart = 1'b0;
      checkVal({tag, "_latency"}, 64'(cyc), 64'd33);
      checkVal({tag, "_busyHeld"}, 64'(idleCyc), 64'd0);
      checkVal({tag, "_hi"}, {32'd0, oHI}, {32'd0, expHi});
      checkVal({tag, "_lo"}, {32'd0, oLO}, {32'd0, expLo});
      checkVal({tag, "_dbz"}, {63'd0, oDivByZero}, {63'd0, expDbz});
      checkVal({tag, "_busyAtDone"}, {63'd0, oBusy}, 64'd0);
      @(negedge iCLK);
      checkVal({tag, "_donePulse"}, {62'd0, oDone, oDivByZero}, 64'd0);
   endtask

   task automatic runMt(input string tag, input logic [4:0] op, input logic [W-1:0] a);
      @(negedge iCLK);
      iStart = 1'b1; iOp = op; iA = a; iB = $urandom;
      @(negedge iCLK);
      iStart = 1'b0;
      checkVal({tag, "_noBusyDone"}, {62'd0, oBusy, oDone}, 64'd0);
   endtask

   // Issue an op expected to be ignored and watch that nothing starts.
   task automatic runNoOp(input string tag, input logic [4:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b);
      int active;
      @(negedge iCLK);
      iStart = 1'b1; iOp = op; iA = a; iB = b;
      @(negedge iCLK);
      iStart = 1'b0;
      active = 0;
      for (int i = 0; i < 40; i++) begin
         if (oBusy || oDone) active++;
         @(negedge iCLK);
      end
      checkVal({tag, "_neverBusy"}, 64'(active), 64'd0);
   endtask

   // ---------------- sequence ----------------
   initial begin
      int active;
      iRST = 1'b1; iStart = 1'b0; iOp = '0; iA = '0; iB = '0;
      repeat (2) @(negedge iCLK);
      checkVal("reset_hilo", {oHI, oLO}, 64'd0);
      checkVal("reset_flags", {61'd0, oBusy, oDone, oDivByZero}, 64'd0);
      iRST = 1'b0;

      runMd("mult_7_m3",   OPMULT,  32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 0);
      runMd("mult_m4_m5",  OPMULT,  32'hFFFFFFFC, 32'hFFFFFFFB, 32'h0,        32'd20,       1'b0, 0);
      runMd("multu_max",   OPMULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 0);
      runMd("div_m7_2",    OPDIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 0);
      runMd("div_7_m2",    OPDIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 0);
      runMd("divu_100_7",  OPDIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 0);
      runMd("div_min_m1",  OPDIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0, 0);
      runMd("busy_poke",   OPMULT,  32'd2,        32'd3,        32'h0,        32'd6,        1'b0, 5);
      runMd("div_5_0",     OPDIV,   32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1, 0);
      runMd("div_m5_0",    OPDIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, 0);

      // Reset during a multiply: HI/LO cleared, operation abandoned.
      @(negedge iCLK);
      iStart = 1'b1; iOp = OPMULT; iA = 32'd7; iB = 32'hFFFFFFFD;
      @(negedge iCLK);
      iStart = 1'b0;
      repeat (10) @(negedge iCLK);
      iRST = 1'b1;
      #1;
      checkVal("midrst_hilo", {oHI, oLO}, 64'd0);
      checkVal("midrst_busy", {63'd0, oBusy}, 64'd0);
      @(negedge iCLK);
      iRST = 1'b0;
      active = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge iCLK);
         if (oBusy || oDone) active++;
      end
      checkVal("midrst_noDone", 64'(active), 64'd0);

      runMt("mtlo_a", OPMTLO, 32'hAAAA5555);
      runMt("mthi", OPMTHI, 32'h1234);
      checkVal("mt_hi", {32'd0, oHI}, 64'h1234);
      checkVal("mt_lo", {32'd0, oLO}, 64'hAAAA5555);
      runNoOp("unlisted", 5'h1F, 32'd9, 32'd9);
      checkVal("unlisted_hilo", {oHI, oLO}, 64'h00001234_AAAA5555);
      runMt("mtlo_0", OPMTLO, 32'h0);

`ifdef MULDIV_MADD_EN
      runMd("madd_2_3", OPMADD, 32'd2, 32'd3, 32'h1234, 32'd6, 1'b0, 0);
      runMd("msub_2_3", OPMSUB, 32'd2, 32'd3, 32'h1234, 32'd0, 1'b0, 0);
`else
      runNoOp("madd_off", OPMADD, 32'd2, 32'd3);
      checkVal("madd_off_hilo", {oHI, oLO}, 64'h00001234_00000000);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
